// File: rtl/mac_seq_if.sv
// Job, operand-read, mac and result signals between mac_seq and its neighbours.
// master is the controller's view; slave is the surrounding system's view.
interface mac_seq_if #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned LEN_W  = 8
);
    localparam int unsigned RES_W = 24;

    logic              i_start;
    logic [1:0]        i_mode;
    logic [ADDR_W-1:0] i_base_addr;
    logic [LEN_W-1:0]  i_len;
    logic              o_busy;
    logic              o_err;
    logic              o_rd_en;
    logic [ADDR_W-1:0] o_rd_addr;
    logic              i_rd_ready;
    logic [1:0]        o_mac_mode;
    logic [RES_W-1:0]  o_mac_psum;
    logic [RES_W-1:0]  i_mac_result;
    logic              o_valid;
    logic [RES_W-1:0]  o_result;
    logic              i_ready;

    modport master (
        input  i_start, i_mode, i_base_addr, i_len, i_rd_ready, i_mac_result, i_ready,
        output o_busy, o_err, o_rd_en, o_rd_addr, o_mac_mode, o_mac_psum, o_valid, o_result
    );

    modport slave (
        output i_start, i_mode, i_base_addr, i_len, i_rd_ready, i_mac_result, i_ready,
        input  o_busy, o_err, o_rd_en, o_rd_addr, o_mac_mode, o_mac_psum, o_valid, o_result
    );
endinterface

// File: rtl/mac_seq.sv
// Sequencing controller for the combinational mac: issues one chunk read per cycle,
// feeds the accumulator back as psum and returns the final sum over valid/ready.
module mac_seq #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned LEN_W  = 8
) (
    input  logic      i_clk,
    input  logic      i_rst_n,
    mac_seq_if.master bus
);
    localparam int unsigned RES_W        = 24;
    localparam logic [1:0]  MODE_ILLEGAL = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        mode_q, mode_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic [RES_W-1:0]  acc_q, acc_d;
    logic [RES_W-1:0]  result_q, result_d;
    logic              dvld_q, dvld_d;
    logic              rd_en_q, rd_en_d;
    logic              valid_q, valid_d;
    logic              err_q, err_d;
    logic              busy_q, busy_d;
    logic              accept;

    assign accept = rd_en_q & bus.i_rd_ready;

    // Next-state and registered-output logic
    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        addr_d   = addr_q;
        len_d    = len_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        result_d = result_q;
        dvld_d   = 1'b0;
        rd_en_d  = rd_en_q;
        valid_d  = valid_q;
        err_d    = 1'b0;

        // Data for an accepted read arrives one cycle later; capture the mac sum then
        if (dvld_q) begin
            acc_d = bus.i_mac_result;
        end

        unique case (state_q)
            IDLE: begin
                if (bus.i_start) begin
                    if (bus.i_mode == MODE_ILLEGAL) begin
                        err_d = 1'b1;
                    end else begin
                        mode_d = bus.i_mode;
                        acc_d  = '0;
                        if (bus.i_len == '0) begin
                            state_d  = DONE;
                            valid_d  = 1'b1;
                            result_d = '0;
                        end else begin
                            state_d = RUN;
                            addr_d  = bus.i_base_addr;
                            len_d   = bus.i_len;
                            cnt_d   = '0;
                            rd_en_d = 1'b1;
                        end
                    end
                end
            end
            RUN: begin
                if (accept) begin
                    cnt_d  = cnt_q + LEN_W'(1);
                    addr_d = addr_q + ADDR_W'(1);
                    dvld_d = 1'b1;
                    if (cnt_q + LEN_W'(1) == len_q) begin
                        state_d = DRAIN;
                        rd_en_d = 1'b0;
                    end
                end
            end
            DRAIN: begin
                state_d  = DONE;
                valid_d  = 1'b1;
                result_d = acc_d;
            end
            DONE: begin
                if (bus.i_ready) begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= IDLE;
            mode_q   <= '0;
            addr_q   <= '0;
            len_q    <= '0;
            cnt_q    <= '0;
            acc_q    <= '0;
            result_q <= '0;
            dvld_q   <= 1'b0;
            rd_en_q  <= 1'b0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            addr_q   <= addr_d;
            len_q    <= len_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            dvld_q   <= dvld_d;
            rd_en_q  <= rd_en_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
            busy_q   <= busy_d;
        end
    end

    assign bus.o_busy     = busy_q;
    assign bus.o_err      = err_q;
    assign bus.o_rd_en    = rd_en_q;
    assign bus.o_rd_addr  = addr_q;
    assign bus.o_mac_mode = mode_q;
    assign bus.o_mac_psum = acc_q;
    assign bus.o_valid    = valid_q;
    assign bus.o_result   = result_q;
endmodule

// File: tb/tb_mac_seq.sv
// Randomized bench for mac_seq: emulates operand buffer and mac, and compares every
// cycle against a job-level model of reads issued, chunks accumulated and handshakes.
module tb_mac_seq;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mac_seq_if #(.ADDR_W(8), .LEN_W(8)) bus ();
    mac_seq #(.ADDR_W(8), .LEN_W(8)) dut (.i_clk(clk), .i_rst_n(rst_n), .bus(bus));

    int n_chk = 0;
    int n_pass = 0;

    int         mem [256];    // per-address chunk dot-product contribution
    int         dchunk = 0;   // data presented to the mac this cycle
    logic [7:0] rd_log [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", name, act, exp);
    endtask

    // mac behaviour: INT8/INT4 wrap at 24 bits, VSQ saturates to signed 24 bits
    function automatic logic [23:0] mac_fn(input logic [1:0] m, input logic [23:0] p, input int c);
        longint s;
        s = longint'($signed(p)) + longint'(c);
        if (m == 2'd2) begin
            if (s > 64'sd8388607) s = 64'sd8388607;
            if (s < -64'sd8388608) s = -64'sd8388608;
        end
        return 24'(s);
    endfunction

    // Operand buffer: accepted read's chunk shows up next cycle; junk otherwise
    always @(posedge clk) begin
        if (bus.o_rd_en && bus.i_rd_ready) dchunk <= mem[int'(bus.o_rd_addr)];
        else dchunk <= int'($urandom_range(0, 32'h00FF_FFFF));
    end
    always_comb bus.i_mac_result = mac_fn(bus.o_mac_mode, bus.o_mac_psum, dchunk);

    // Job-level reference model
    bit          m_busy = 0, m_err = 0, m_dph = 0;
    logic [1:0]  m_mode = '0;
    logic [7:0]  m_base = '0;
    int          m_len = 0, m_issued = 0, m_accum = 0;
    logic [23:0] m_acc = '0;

    initial forever begin
        bit acc_now, exp_valid;
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_busy = 0; m_err = 0; m_dph = 0; m_mode = '0; m_base = '0;
            m_len = 0; m_issued = 0; m_accum = 0; m_acc = '0;
        end else begin
            exp_valid = m_busy && (m_issued == m_len) && !m_dph;
            acc_now   = m_busy && (m_issued < m_len) && bus.i_rd_ready;
            if (m_dph) begin
                m_acc = mac_fn(m_mode, m_acc, mem[int'(8'(m_base + 8'(m_accum)))]);
                m_accum++;
            end
            if (acc_now) m_issued++;
            m_dph = acc_now;
            m_err = 0;
            if (exp_valid && bus.i_ready) m_busy = 0;
            else if (!m_busy && bus.i_start) begin
                if (bus.i_mode == 2'd3) m_err = 1;
                else begin
                    m_busy = 1; m_mode = bus.i_mode; m_base = bus.i_base_addr;
                    m_len = int'(bus.i_len); m_issued = 0; m_accum = 0; m_acc = '0;
                end
            end
        end
    end

    // Per-cycle comparison against the model
    initial forever begin
        bit exp_valid, exp_rd;
        @(negedge clk);
        if (rst_n) begin
            exp_valid = m_busy && (m_issued == m_len) && !m_dph;
            exp_rd    = m_busy && (m_issued < m_len);
            chk("busy", 32'(bus.o_busy), 32'(m_busy));
            chk("err", 32'(bus.o_err), 32'(m_err));
            chk("rd_en", 32'(bus.o_rd_en), 32'(exp_rd));
            if (exp_rd) chk("rd_addr", 32'(bus.o_rd_addr), 32'(8'(m_base + 8'(m_issued))));
            chk("psum", 32'(bus.o_mac_psum), 32'(m_acc));
            chk("valid", 32'(bus.o_valid), 32'(exp_valid));
            if (exp_valid) chk("result", 32'(bus.o_result), 32'(m_acc));
            chk("mac_mode", 32'(bus.o_mac_mode), 32'(m_mode));
        end
    end

    // Drive one job from IDLE to its result handshake
    task automatic run_job(input logic [1:0] mode, input logic [7:0] base, input logic [7:0] len,
                           input bit rnd, input int stall_at, input int stall_n, input int hold,
                           input bit poke, output int vcyc, output logic [23:0] res);
        int t, cnt, stalled, held;
        bit acc_now, done;
        vcyc = -1; res = '0; cnt = 0; stalled = 0; held = 0; done = 0;
        rd_log.delete();
        bus.i_start = 1'b1; bus.i_mode = mode; bus.i_base_addr = base; bus.i_len = len;
        bus.i_ready = 1'b0; bus.i_rd_ready = 1'b1;
        @(posedge clk); #1;
        bus.i_start = 1'b0;
        bus.i_mode = 2'($urandom); bus.i_base_addr = 8'($urandom); bus.i_len = 8'($urandom);
        t = 1;
        while (!done && t < 400) begin
            if (rnd) bus.i_rd_ready = ($urandom_range(0, 3) != 0);
            else begin
                bus.i_rd_ready = !(cnt == stall_at && stalled < stall_n);
                if (!bus.i_rd_ready && bus.o_rd_en) stalled++;
            end
            bus.i_start = poke && (t == 2 || (bus.o_valid && held == 0));
            bus.i_ready = 1'b0;
            if (bus.o_valid) begin
                if (vcyc < 0) begin vcyc = t; res = bus.o_result; end
                if (held < hold) held++;
                else begin bus.i_ready = 1'b1; done = 1; end
            end
            acc_now = bus.o_rd_en && bus.i_rd_ready;
            if (acc_now) rd_log.push_back(bus.o_rd_addr);
            @(posedge clk); #1;
            if (acc_now) cnt++;
            t++;
        end
        if (!done) chk("job_timeout", 32'd0, 32'd1);
        bus.i_start = 1'b0; bus.i_ready = 1'b0;
    endtask

    initial begin
        int          vc;
        logic [23:0] rs;
        logic [7:0]  exp_addr [4];
        logic [7:0]  b;
        logic [7:0]  l;
        bus.i_start = 1'b0; bus.i_mode = '0; bus.i_base_addr = '0; bus.i_len = '0;
        bus.i_rd_ready = 1'b0; bus.i_ready = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = 0;
        #23 rst_n = 1'b1;
        @(posedge clk); #1;

        // INT8 basic: a=b=1 gives 32 per chunk
        for (int i = 0; i < 4; i++) mem[16 + i] = 32;
        run_job(2'd0, 8'h10, 8'd4, 0, -1, 0, 0, 0, vc, rs);
        chk("int8_result", 32'(rs), 32'd128);
        chk("int8_valid_cycle", 32'(vc), 32'd6);
        for (int i = 0; i < 4; i++) chk("int8_addr", 32'(rd_log[i]), 32'(16 + i));

        // INT4 with a 2-cycle stall on the 2nd issue: 256 per chunk
        for (int i = 0; i < 3; i++) mem[48 + i] = 256;
        run_job(2'd1, 8'h30, 8'd3, 0, 1, 2, 0, 0, vc, rs);
        chk("int4_result", 32'(rs), 32'd768);
        chk("int4_valid_cycle", 32'(vc), 32'd7);

        // Address wrap, 3 cycles of result backpressure, starts poked while busy
        exp_addr[0] = 8'hFE; exp_addr[1] = 8'hFF; exp_addr[2] = 8'h00; exp_addr[3] = 8'h01;
        for (int i = 0; i < 4; i++) mem[int'(exp_addr[i])] = 10 + i;
        run_job(2'd0, 8'hFE, 8'd4, 0, -1, 0, 3, 1, vc, rs);
        for (int i = 0; i < 4; i++) chk("wrap_addr", 32'(rd_log[i]), 32'(exp_addr[i]));
        chk("wrap_result", 32'(rs), 32'd46);

        // len 0 finishes in cycle 1 with a zero result
        run_job(2'd1, 8'h55, 8'd0, 0, -1, 0, 0, 0, vc, rs);
        chk("len0_valid_cycle", 32'(vc), 32'd1);
        chk("len0_result", 32'(rs), 32'd0);
        chk("len0_no_reads", 32'(rd_log.size()), 32'd0);

        // Illegal mode: one-cycle err, never busy
        bus.i_start = 1'b1; bus.i_mode = 2'd3; bus.i_len = 8'd5;
        @(posedge clk); #1;
        bus.i_start = 1'b0;
        chk("mode3_err", 32'(bus.o_err), 32'd1);
        chk("mode3_busy", 32'(bus.o_busy), 32'd0);
        @(posedge clk); #1;
        chk("mode3_err_pulse", 32'(bus.o_err), 32'd0);

        // VSQ saturation is passed through unchanged
        mem[32] = 24'h60_0000; mem[33] = 24'h60_0000;
        run_job(2'd2, 8'h20, 8'd2, 0, -1, 0, 1, 0, vc, rs);
        chk("vsq_result", 32'(rs), 32'h7F_FFFF);

        // Reset asserted in the 2nd RUN cycle of a mode-1 job
        mem[64] = 5; mem[65] = 6; mem[66] = 7; mem[67] = 8;
        bus.i_start = 1'b1; bus.i_mode = 2'd1; bus.i_base_addr = 8'h40; bus.i_len = 8'd4;
        bus.i_rd_ready = 1'b1;
        @(posedge clk); #1;
        bus.i_start = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("rst_busy", 32'(bus.o_busy), 32'd0);
        chk("rst_err", 32'(bus.o_err), 32'd0);
        chk("rst_rd_en", 32'(bus.o_rd_en), 32'd0);
        chk("rst_rd_addr", 32'(bus.o_rd_addr), 32'd0);
        chk("rst_psum", 32'(bus.o_mac_psum), 32'd0);
        chk("rst_valid", 32'(bus.o_valid), 32'd0);
        chk("rst_result", 32'(bus.o_result), 32'd0);
        chk("rst_mac_mode", 32'(bus.o_mac_mode), 32'd0);
        @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        run_job(2'd1, 8'h40, 8'd3, 0, -1, 0, 0, 0, vc, rs);
        chk("post_rst_result", 32'(rs), 32'd18);

        // Random jobs, stalls and backpressure
        for (int j = 0; j < 30; j++) begin
            b = 8'($urandom);
            l = 8'($urandom_range(0, 10));
            for (int i = 0; i < int'(l); i++)
                mem[int'(8'(b + 8'(i)))] = int'($urandom_range(0, 32'h00C0_0000)) - 32'sh0060_0000;
            run_job(2'($urandom_range(0, 2)), b, l, 1, -1, 0, int'($urandom_range(0, 3)),
                    bit'($urandom_range(0, 1)), vc, rs);
        end

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
